// File: rtl/payload_fifo_slice_if.sv
// payload_fifo_slice_if: source/destination valid-ready payload bundle
interface payload_fifo_slice_if #(
  parameter int PW = 67
);
  logic [PW-1:0] in_payload;
  logic          svalid;
  logic          sready;
  logic [PW-1:0] out_payload;
  logic          dvalid;
  logic          dready;
  modport master (
    output in_payload, svalid, dready,
    input  sready, out_payload, dvalid
  );
  modport slave (
    input  in_payload, svalid, dready,
    output sready, out_payload, dvalid
  );
endinterface

// File: rtl/payload_fifo_slice.sv
// payload_fifo_slice: registered-handshake circular FIFO with occupancy, almost-full, flush and source protocol checker
module payload_fifo_slice #(
  parameter int ID_WIDTH   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  localparam int PW = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  payload_fifo_slice_if.slave   bus,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  proto_err
);
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] shadow;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] nxt;
  logic          sready_q, dvalid_q, stall, push, pop;
  assign push            = bus.svalid && sready_q;
  assign pop             = dvalid_q && bus.dready;
  assign nxt             = count + CW'(push) - CW'(pop);
  assign bus.sready      = sready_q;
  assign bus.dvalid      = dvalid_q;
  assign bus.out_payload = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= bus.in_payload;
    if (bus.svalid && !sready_q) shadow <= bus.in_payload;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sready_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      almost_full <= 1'b0;
      proto_err   <= 1'b0;
      stall       <= 1'b0;
    end else begin
      if (stall && (!bus.svalid || bus.in_payload != shadow)) proto_err <= 1'b1;
      // a flush edge disarms the check for the following cycle
      stall <= !flush && bus.svalid && !sready_q;
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        sready_q    <= 1'b1;
        dvalid_q    <= 1'b0;
        almost_full <= 1'b0;
      end else begin
        wr_ptr      <= wr_ptr + AW'(push);
        rd_ptr      <= rd_ptr + AW'(pop);
        count       <= nxt;
        dvalid_q    <= nxt != '0;
        sready_q    <= nxt < CW'(DEPTH);
        almost_full <= nxt >= CW'(AF_LEVEL);
      end
    end
  end
endmodule

// File: tb/tb_payload_fifo_slice.sv
// tb_payload_fifo_slice: randomized and directed stimulus with a queue-based scoreboard for payload_fifo_slice
module tb_payload_fifo_slice;
  localparam int PW = 67;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0;
  logic [2:0] count;
  logic almost_full, proto_err;
  logic acc = 0;
  int checks = 0, errors = 0;
  payload_fifo_slice_if #(.PW(PW)) bus ();
  payload_fifo_slice dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
                          .count(count), .almost_full(almost_full), .proto_err(proto_err));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  logic [PW-1:0] q[$];
  logic [PW-1:0] m_shadow;
  logic m_rst = 1, m_err = 0, m_stall = 0, m_rdy;
  int sz;
  always @(negedge clk) begin
    sz = q.size();
    chk("count", count, sz);
    chk("dvalid", bus.dvalid, sz != 0);
    chk("sready", bus.sready, !m_rst && sz < DEPTH);
    chk("almost_full", almost_full, sz >= DEPTH - 1);
    chk("proto_err", proto_err, m_err);
    if (sz != 0) chk("out_payload", bus.out_payload, q[0]);
    if (rst) begin
      q.delete();
      m_rst = 1; m_err = 0; m_stall = 0;
    end else begin
      m_rdy = !m_rst && sz < DEPTH;
      if (m_stall && (!bus.svalid || bus.in_payload != m_shadow)) m_err = 1;
      if (flush) begin
        q.delete();
        m_stall = 0;
      end else begin
        m_stall = bus.svalid && !m_rdy;
        if (m_stall) m_shadow = bus.in_payload;
        if (sz != 0 && bus.dready) void'(q.pop_front());
        if (bus.svalid && m_rdy) q.push_back(bus.in_payload);
      end
      m_rst = 0;
    end
  end
  task automatic step();
    @(negedge clk);
    acc = bus.svalid && bus.sready && !flush && !rst;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [PW-1:0] mk(input int id, input int addr, input int data);
    return {3'(id), 32'(addr), 32'(data)};
  endfunction
  task automatic send(input logic [PW-1:0] p);
    int n = 0;
    bus.svalid = 1; bus.in_payload = p;
    do begin step(); n++; end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    bus.svalid = 0;
  endtask
  task automatic do_reset();
    rst = 1; step(); rst = 0; step();
  endtask
  initial begin
    int sent, cyc;
    bus.svalid = 0; bus.dready = 0; bus.in_payload = '0;
    repeat (2) step();
    chk("reset_sready", bus.sready, 0);
    rst = 0;
    step();
    chk("post_reset_sready", bus.sready, 1);
    for (int i = 0; i < 4; i++) send(mk(i, 32'h100 + i, 32'hd0 + i));
    chk("fill_count", count, 4);
    chk("fill_sready", bus.sready, 0);
    chk("fill_af", almost_full, 1);
    bus.svalid = 1; bus.in_payload = mk(4, 32'h104, 32'hd4);
    repeat (3) step();
    chk("held_no_accept", acc, 0);
    chk("held_no_err", proto_err, 0);
    bus.dready = 1; step(); bus.dready = 0;
    chk("full_pop_count", count, 3);
    chk("full_pop_sready", bus.sready, 1);
    step();
    chk("refill_accept", acc, 1);
    chk("refill_count", count, 4);
    bus.svalid = 0; bus.dready = 1;
    repeat (6) step();
    chk("drain_count", count, 0);
    for (int i = 0; i < 16; i++) begin
      send(mk(1, 32'h200, i));
      chk("stream_count", count, 1);
      chk("stream_dvalid", bus.dvalid, 1);
    end
    step();
    chk("stream_end_count", count, 0);
    sent = 0; cyc = 0; acc = 0;
    while (sent < 1000 && cyc < 20000) begin
      bus.dready = 1'($urandom);
      if (!bus.svalid || acc) begin
        bus.svalid = 1'($urandom);
        bus.in_payload = {3'($urandom), 32'($urandom), 32'(sent)};
      end
      step();
      cyc++;
      if (acc) sent++;
    end
    chk("random_done", sent, 1000);
    bus.svalid = 0; bus.dready = 1;
    repeat (8) step();
    chk("random_drain", count, 0);
    bus.dready = 0;
    for (int i = 0; i < 3; i++) send(mk(2, 32'h300, i));
    chk("pre_flush_count", count, 3);
    flush = 1; bus.svalid = 1; bus.dready = 1; bus.in_payload = mk(7, 32'hdead, 32'hbeef);
    step();
    flush = 0; bus.svalid = 0; bus.dready = 0;
    chk("flush_count", count, 0);
    chk("flush_dvalid", bus.dvalid, 0);
    chk("flush_sready", bus.sready, 1);
    repeat (2) step();
    chk("flush_discard", bus.dvalid, 0);
    for (int i = 0; i < 4; i++) send(mk(3, 32'h400, i));
    bus.svalid = 1; bus.in_payload = mk(5, 32'h10, 32'h55);
    step();
    chk("stall_no_err", proto_err, 0);
    bus.in_payload = mk(5, 32'h14, 32'h55);
    step();
    chk("addr_change_err", proto_err, 1);
    bus.svalid = 0; flush = 1; step(); flush = 0;
    chk("err_survives_flush", proto_err, 1);
    step();
    chk("err_sticky", proto_err, 1);
    do_reset();
    chk("err_cleared_rst", proto_err, 0);
    for (int i = 0; i < 4; i++) send(mk(4, 32'h500, i));
    bus.svalid = 1; bus.in_payload = mk(6, 32'h10, 32'h66);
    step();
    bus.svalid = 0;
    step();
    chk("drop_valid_err", proto_err, 1);
    do_reset();
    chk("drop_err_cleared", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
